// File: rtl/data_memory_ctrl.sv
// Word-wide backing data memory behind the data cache. A fixed-latency
// controller serves one read or write per interupt_start/interupt_stop handshake.
module data_memory_ctrl #(
    parameter int ADDR_WORDS = 1024,
    parameter int LATENCY    = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     mem_addr,
    input  logic            mem_we,
    input  logic [3:0][7:0] mem_data_in,
    input  logic            interupt_start,
    input  logic            interupt_second,
    output logic [3:0][7:0] mem_data_out,
    output logic            interupt_stop,
    output logic            busy
);

    localparam int IDX_W = $clog2(ADDR_WORDS);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE,
        S_RELEASE
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [IDX_W-1:0]   r_idx;
    logic               r_we;
    logic               r_second;
    logic [31:0]        r_wdata;
    logic [31:0]        r_mem [ADDR_WORDS];

    logic [IDX_W-1:0]   w_idx;
    logic               w_accept;
    logic               w_commit;
    logic               w_unused_addr;

    assign w_idx         = mem_addr[IDX_W+1:2];
    assign w_unused_addr = ^{mem_addr[31:IDX_W+2], mem_addr[1:0]};

    // A write-back flagged with interupt_second may hand straight over to the fill
    // from DONE, so the two completions sit LATENCY+1 cycles apart.
    assign w_accept = interupt_start &&
                      ((r_state == S_IDLE) || ((r_state == S_DONE) && r_second));

    // Commit happens only on the WAIT->DONE edge; a reset on that edge drops it.
    assign w_commit = !reset && (r_state == S_WAIT) && (r_cnt == '0);

    always_ff @(posedge clk) begin
        if (w_commit && r_we) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            interupt_stop <= 1'b0;
            busy          <= 1'b0;
            mem_data_out  <= '0;
        end else begin
            interupt_stop <= 1'b0;
            if (w_accept) begin
                r_idx    <= w_idx;
                r_we     <= mem_we;
                r_wdata  <= mem_data_in;
                r_second <= interupt_second;
                // LATENCY=1 still spends one edge in WAIT with the counter at
                // zero, keeping completion exactly LATENCY edges after accept.
                r_cnt    <= CNT_W'(LATENCY - 1);
                r_state  <= S_WAIT;
                busy     <= 1'b1;
            end else begin
                case (r_state)
                    S_WAIT: begin
                        if (r_cnt == '0) begin
                            r_state       <= S_DONE;
                            interupt_stop <= 1'b1;
                            mem_data_out  <= r_we ? r_wdata : r_mem[r_idx];
                        end else begin
                            r_cnt <= r_cnt - CNT_W'(1);
                        end
                    end
                    S_DONE: begin
                        if (r_second) begin
                            r_state <= S_IDLE;
                            busy    <= 1'b0;
                        end else begin
                            r_state <= S_RELEASE;
                        end
                    end
                    S_RELEASE: begin
                        if (!interupt_start) begin
                            r_state <= S_IDLE;
                            busy    <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Scoreboard bench for data_memory_ctrl: expected data and completion cycle are
// queued when a request is driven and compared when interupt_stop pulses.
module tb_data_memory_ctrl;

    localparam int LAT   = 4;
    localparam int WORDS = 1024;

    logic            clk;
    logic            reset;
    logic [31:0]     mem_addr;
    logic            mem_we;
    logic [3:0][7:0] mem_data_in;
    logic            interupt_start;
    logic            interupt_second;
    logic [3:0][7:0] mem_data_out;
    logic            interupt_stop;
    logic            busy;

    data_memory_ctrl #(.ADDR_WORDS(WORDS), .LATENCY(LAT)) dut (
        .clk             (clk),
        .reset           (reset),
        .mem_addr        (mem_addr),
        .mem_we          (mem_we),
        .mem_data_in     (mem_data_in),
        .interupt_start  (interupt_start),
        .interupt_second (interupt_second),
        .mem_data_out    (mem_data_out),
        .interupt_stop   (interupt_stop),
        .busy            (busy)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [31:0] exp_q [$];
    int          cyc_q [$];
    logic [31:0] model [int];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Called at a negedge: drives one request and queues its expected result.
    task automatic send(input logic [31:0] a, input logic we, input logic [31:0] d,
                        input logic sec);
        int          idx;
        logic [31:0] e;
        idx = int'(a[11:2]);
        if (we) begin
            e          = d;
            model[idx] = d;
        end else begin
            e = model.exists(idx) ? model[idx] : 32'h0;
        end
        mem_addr        = a;
        mem_we          = we;
        mem_data_in     = d;
        interupt_second = sec;
        interupt_start  = 1'b1;
        exp_q.push_back(e);
        cyc_q.push_back(cyc + 1 + LAT);
    endtask

    task automatic wait_stop();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (interupt_stop !== 1'b1 && n < 40);
        if (interupt_stop !== 1'b1) chk("stop_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("idle_busy", {31'd0, busy}, 32'd0);
    endtask

    always @(negedge clk) begin
        if (interupt_stop === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("spurious_stop", 32'd1, 32'd0);
            end else begin
                chk("rdata", mem_data_out, exp_q.pop_front());
                chk("stop_cycle", cyc, cyc_q.pop_front());
                chk("busy_in_done", {31'd0, busy}, 32'd1);
            end
        end
    end

    initial begin
        int          c1;
        int          c2;
        logic [7:0]  bytes_exp [4];
        reset           = 1'b1;
        mem_addr        = '0;
        mem_we          = 1'b0;
        mem_data_in     = '0;
        interupt_start  = 1'b0;
        interupt_second = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_stop", {31'd0, interupt_stop}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_dout", mem_data_out, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Plain read of untouched memory
        send(32'h10, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        chk("t1_busy_wait", {31'd0, busy}, 32'd1);
        wait_stop();
        interupt_start = 1'b0;
        wait_idle();

        // Byte ordering of a write then read
        send(32'h20, 1'b1, 32'hDDCCBBAA, 1'b0);
        wait_stop();
        interupt_start = 1'b0;
        wait_idle();
        @(negedge clk);
        send(32'h20, 1'b0, 32'h0, 1'b0);
        wait_stop();
        bytes_exp = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        for (int i = 0; i < 4; i++) chk("t2_byte", {24'd0, mem_data_out[i]}, {24'd0, bytes_exp[i]});
        interupt_start = 1'b0;
        wait_idle();

        // Write-back followed by an immediate fill
        send(32'h60, 1'b1, 32'hCAFEBABE, 1'b1);
        wait_stop();
        c1 = cyc;
        send(32'h60, 1'b0, 32'h0, 1'b0);
        wait_stop();
        c2 = cyc;
        chk("t3_gap", c2 - c1, LAT + 1);
        interupt_start = 1'b0;
        wait_idle();

        // Upper address bits alias onto the same word
        send(32'h0000_0040, 1'b1, 32'h12345678, 1'b0);
        wait_stop();
        interupt_start = 1'b0;
        wait_idle();
        send(32'h0000_1040, 1'b0, 32'h0, 1'b0);
        wait_stop();
        chk("t4_alias", mem_data_out, 32'h12345678);
        interupt_start = 1'b0;
        wait_idle();

        // Reset during WAIT drops the write
        send(32'h30, 1'b1, 32'h0BADF00D, 1'b0);
        wait_stop();
        interupt_start = 1'b0;
        wait_idle();
        mem_addr       = 32'h30;
        mem_we         = 1'b1;
        mem_data_in    = 32'hDEADBEEF;
        interupt_start = 1'b1;
        repeat (2) @(negedge clk);
        chk("t5_busy_pre", {31'd0, busy}, 32'd1);
        reset          = 1'b1;
        interupt_start = 1'b0;
        @(negedge clk);
        chk("t5_busy_rst", {31'd0, busy}, 32'd0);
        chk("t5_stop_rst", {31'd0, interupt_stop}, 32'd0);
        reset = 1'b0;
        repeat (LAT + 2) @(negedge clk);
        send(32'h30, 1'b0, 32'h0, 1'b0);
        wait_stop();
        interupt_start = 1'b0;
        wait_idle();

        // Inputs changing in WAIT and start held through RELEASE
        send(32'h50, 1'b1, 32'h11223344, 1'b0);
        @(negedge clk);
        mem_addr    = 32'h54;
        mem_we      = 1'b0;
        mem_data_in = 32'hFFFFFFFF;
        wait_stop();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t6_release_busy", {31'd0, busy}, 32'd1);
        end
        interupt_start = 1'b0;
        wait_idle();
        send(32'h54, 1'b0, 32'h0, 1'b0);
        wait_stop();
        interupt_start = 1'b0;
        wait_idle();
        send(32'h50, 1'b0, 32'h0, 1'b0);
        wait_stop();
        interupt_start = 1'b0;
        wait_idle();

        repeat (5) @(negedge clk);
        chk("pending", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
